// File: rtl/debug_bridge.sv
// debug_bridge: UART-side debug controller for the pipelined MIPS core.
//   Decodes one-byte commands received from the UART: 'L' load program,
//   'S' single step, 'C' continuous run, 'D' dump. Dumps are sent as NB-bit
//   words split into DATA_BITS-wide bytes, least-significant byte first, in
//   this order: PC, registers, data memory, ALU result.
//   Optional: define DEBUG_DUMP_CHECKSUM_EN to append an XOR checksum byte
//   after every dump.
// Ports:
//   i_clk, i_reset (async, active low)
//   i_uart_rx_ready/i_uart_rx_data        received byte handshake
//   o_uart_tx_ready/o_uart_tx_data, i_uart_tx_done   transmit handshake
//   i_mips_pc/register/mem_data/alu_result/halt      core observation
//   o_step                                 pipeline clock enable
//   o_mips_register_number, o_mips_memory_address    dump read addresses
//   o_instruction_write_enable/address/data          program load port
//   o_state_debug                          FSM state code for LEDs
module debug_bridge #(
   parameter int NB             = 32,
   parameter int DATA_BITS      = 8,
   parameter int NUM_REGS       = 32,
   parameter int MEM_DUMP_DEPTH = 16,
   parameter int IMEM_DEPTH     = 256,
   parameter int MAX_RUN_CYCLES = 65535
) (
   input  logic                 i_clk,
   input  logic                 i_reset,
   input  logic                 i_uart_rx_ready,
   input  logic [DATA_BITS-1:0] i_uart_rx_data,
   input  logic                 i_uart_tx_done,
   output logic                 o_uart_tx_ready,
   output logic [DATA_BITS-1:0] o_uart_tx_data,
   input  logic [NB-1:0]        i_mips_pc,
   input  logic [NB-1:0]        i_mips_register,
   input  logic [NB-1:0]        i_mips_mem_data,
   input  logic [NB-1:0]        i_mips_alu_result,
   input  logic                 i_mips_halt,
   output logic                 o_step,
   output logic [NB-1:0]        o_mips_register_number,
   output logic [NB-1:0]        o_mips_memory_address,
   output logic                 o_instruction_write_enable,
   output logic [NB-1:0]        o_instruction_address,
   output logic [NB-1:0]        o_instruction_data,
   output logic [3:0]           o_state_debug
);

   localparam int BPW = NB / DATA_BITS;                   // bytes per word
   localparam int BIW = (BPW > 1) ? $clog2(BPW) : 1;
   localparam int TW  = NUM_REGS + MEM_DUMP_DEPTH + 2;    // words per dump
   localparam int WW  = $clog2(TW);
   localparam int RCW = $clog2(MAX_RUN_CYCLES + 1);
   localparam int NBB = NB / 8;                           // byte-address stride

   typedef enum logic [3:0] {
      IDLE       = 4'd0,
      LOAD_CNT   = 4'd1,
      LOAD_DATA  = 4'd2,
      LOAD_ACK   = 4'd3,
      STEP       = 4'd4,
      RUN        = 4'd5,
      DUMP_FETCH = 4'd6,
      DUMP_SEND  = 4'd7,
      DUMP_WAIT  = 4'd8,
      CHK_SEND   = 4'd9
   } state_t;

   state_t               state;
   logic [NB-1:0]        word_buf;   // load assembly or word being dumped
   logic [BIW-1:0]       bidx;
   logic [DATA_BITS-1:0] ld_cnt;
   logic [DATA_BITS-1:0] ld_idx;
   logic [WW-1:0]        widx;
   logic [1:0]           ph;         // fetch phase: drive addr, wait, latch
   logic [RCW-1:0]       run_cnt;
   logic                 sent;       // single-byte send issued, awaiting done
`ifdef DEBUG_DUMP_CHECKSUM_EN
   logic [DATA_BITS-1:0] chk;
`endif

   logic [NB-1:0]        word_nxt;
   logic [NB-1:0]        fetched;
   logic [DATA_BITS-1:0] byte_sel;
   logic                 last_byte;

   always_comb begin
      word_nxt = word_buf;
      word_nxt[bidx*DATA_BITS +: DATA_BITS] = i_uart_rx_data;
   end

   always_comb begin
      fetched = i_mips_mem_data;
      if (widx == '0)                  fetched = i_mips_pc;
      else if (widx == WW'(TW - 1))    fetched = i_mips_alu_result;
      else if (widx <= WW'(NUM_REGS))  fetched = i_mips_register;
   end

   assign byte_sel      = word_buf[bidx*DATA_BITS +: DATA_BITS];
   assign last_byte     = (bidx == BIW'(BPW - 1));
   assign o_state_debug = state;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         state                      <= IDLE;
         word_buf                   <= '0;
         bidx                       <= '0;
         ld_cnt                     <= '0;
         ld_idx                     <= '0;
         widx                       <= '0;
         ph                         <= '0;
         run_cnt                    <= '0;
         sent                       <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
         chk                        <= '0;
`endif
         o_uart_tx_ready            <= 1'b0;
         o_uart_tx_data             <= '0;
         o_step                     <= 1'b0;
         o_mips_register_number     <= '0;
         o_mips_memory_address      <= '0;
         o_instruction_write_enable <= 1'b0;
         o_instruction_address      <= '0;
         o_instruction_data         <= '0;
      end else begin
         o_uart_tx_ready            <= 1'b0;
         o_instruction_write_enable <= 1'b0;
         case (state)
            IDLE: begin
               // Park all sequence counters here so every command starts clean.
               bidx    <= '0;
               widx    <= '0;
               ph      <= '0;
               run_cnt <= '0;
               sent    <= 1'b0;
`ifdef DEBUG_DUMP_CHECKSUM_EN
               chk     <= '0;
`endif
               if (i_uart_rx_ready) begin
                  if (i_uart_rx_data == DATA_BITS'(8'h4C)) state <= LOAD_CNT;
                  else if (i_uart_rx_data == DATA_BITS'(8'h53)) begin
                     state  <= STEP;
                     o_step <= 1'b1;
                  end else if (i_uart_rx_data == DATA_BITS'(8'h43)) begin
                     state  <= RUN;
                     o_step <= 1'b1;
                  end else if (i_uart_rx_data == DATA_BITS'(8'h44)) state <= DUMP_FETCH;
               end
            end
            LOAD_CNT: if (i_uart_rx_ready) begin
               ld_cnt <= i_uart_rx_data;
               ld_idx <= '0;
               state  <= (i_uart_rx_data == '0) ? LOAD_ACK : LOAD_DATA;
            end
            LOAD_DATA: if (i_uart_rx_ready) begin
               word_buf <= word_nxt;
               if (last_byte) begin
                  o_instruction_write_enable <= 1'b1;
                  o_instruction_data         <= word_nxt;
                  o_instruction_address      <= (NB'(ld_idx) & NB'(IMEM_DEPTH - 1)) * NB'(NBB);
                  bidx   <= '0;
                  ld_idx <= ld_idx + DATA_BITS'(1);
                  if (ld_idx + DATA_BITS'(1) == ld_cnt) state <= LOAD_ACK;
               end else bidx <= bidx + BIW'(1);
            end
            LOAD_ACK: begin
               if (!sent) begin
                  o_uart_tx_ready <= 1'b1;
                  o_uart_tx_data  <= DATA_BITS'(8'h06);
                  sent            <= 1'b1;
               end else if (i_uart_tx_done) begin
                  sent  <= 1'b0;
                  state <= IDLE;
               end
            end
            STEP: begin
               o_step <= 1'b0;
               state  <= DUMP_FETCH;
            end
            RUN: begin
               // Halt seen in this step cycle drops o_step on the next one.
               run_cnt <= run_cnt + RCW'(1);
               if (i_mips_halt || run_cnt == RCW'(MAX_RUN_CYCLES - 1)) begin
                  o_step <= 1'b0;
                  state  <= DUMP_FETCH;
               end
            end
            DUMP_FETCH: begin
               case (ph)
                  2'd0: begin
                     if (widx == '0 || widx == WW'(TW - 1)) begin
                        word_buf <= fetched;
                        state    <= DUMP_SEND;
                     end else begin
                        if (widx <= WW'(NUM_REGS))
                           o_mips_register_number <= NB'(widx - WW'(1));
                        else
                           o_mips_memory_address <= NB'(widx - WW'(NUM_REGS + 1)) * NB'(NBB);
                        ph <= 2'd1;
                     end
                  end
                  2'd1: ph <= 2'd2;   // one cycle of read latency
                  default: begin
                     word_buf <= fetched;
                     ph       <= 2'd0;
                     state    <= DUMP_SEND;
                  end
               endcase
            end
            DUMP_SEND: begin
               o_uart_tx_ready <= 1'b1;
               o_uart_tx_data  <= byte_sel;
`ifdef DEBUG_DUMP_CHECKSUM_EN
               chk             <= chk ^ byte_sel;
`endif
               state           <= DUMP_WAIT;
            end
            DUMP_WAIT: if (i_uart_tx_done) begin
               if (last_byte) begin
                  bidx <= '0;
                  if (widx == WW'(TW - 1)) begin
`ifdef DEBUG_DUMP_CHECKSUM_EN
                     state <= CHK_SEND;
`else
                     state <= IDLE;
`endif
                  end else begin
                     widx  <= widx + WW'(1);
                     state <= DUMP_FETCH;
                  end
               end else begin
                  bidx  <= bidx + BIW'(1);
                  state <= DUMP_SEND;
               end
            end
`ifdef DEBUG_DUMP_CHECKSUM_EN
            CHK_SEND: begin
               if (!sent) begin
                  o_uart_tx_ready <= 1'b1;
                  o_uart_tx_data  <= chk;
                  sent            <= 1'b1;
               end else if (i_uart_tx_done) begin
                  sent  <= 1'b0;
                  state <= IDLE;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_debug_bridge.sv
// tb_debug_bridge: table-driven bench for debug_bridge. A second instance
// with a short watchdog and a tiny dump covers the run-cycle limit.
module tb_debug_bridge;

`ifdef DEBUG_DUMP_CHECKSUM_EN
   localparam int CHKB = 1;
`else
   localparam int CHKB = 0;
`endif
   localparam int DUMP_BYTES  = 200 + CHKB;
   localparam int DUMP2_BYTES = 20 + CHKB;   // (2 + 1 + 2) words x 4

   logic        clk, rst_n;
   logic        rx_ready, rx2_ready, tx_done, tx2_done;
   logic [7:0]  rx_data, rx2_data;
   logic [31:0] pc, alu;
   logic        halt, zero_mode;
   logic        tx_ready, tx2_ready, step, step2, we, we2;
   logic [7:0]  tx_data, tx2_data;
   logic [31:0] reg_num, mem_addr, iaddr, idata, reg_data, mem_data;
   logic [31:0] reg_num2, mem_addr2, iaddr2, idata2;
   logic [3:0]  state, state2;

   int checks = 0, fails = 0;
   int tcnt0 = 0, tcnt2 = 0, steps0 = 0, steps2 = 0, txn2 = 0;
   logic [7:0]  txq[$];
   logic [31:0] waq[$], wdq[$];

   function automatic logic [31:0] reg_val(input int idx, input logic z);
      return z ? 32'h0 : (32'hA5000000 ^ (idx * 32'h00010101));
   endfunction
   function automatic logic [31:0] mem_val(input int addr, input logic z);
      return z ? 32'h0 : (32'h3C000000 + addr * 3);
   endfunction

   assign reg_data = reg_val(int'(reg_num), zero_mode);
   assign mem_data = mem_val(int'(mem_addr), zero_mode);

   debug_bridge dut (
      .i_clk(clk), .i_reset(rst_n),
      .i_uart_rx_ready(rx_ready), .i_uart_rx_data(rx_data), .i_uart_tx_done(tx_done),
      .o_uart_tx_ready(tx_ready), .o_uart_tx_data(tx_data),
      .i_mips_pc(pc), .i_mips_register(reg_data), .i_mips_mem_data(mem_data),
      .i_mips_alu_result(alu), .i_mips_halt(halt), .o_step(step),
      .o_mips_register_number(reg_num), .o_mips_memory_address(mem_addr),
      .o_instruction_write_enable(we), .o_instruction_address(iaddr),
      .o_instruction_data(idata), .o_state_debug(state));

   debug_bridge #(.NUM_REGS(2), .MEM_DUMP_DEPTH(1), .MAX_RUN_CYCLES(5)) dut2 (
      .i_clk(clk), .i_reset(rst_n),
      .i_uart_rx_ready(rx2_ready), .i_uart_rx_data(rx2_data), .i_uart_tx_done(tx2_done),
      .o_uart_tx_ready(tx2_ready), .o_uart_tx_data(tx2_data),
      .i_mips_pc(pc), .i_mips_register(32'h0), .i_mips_mem_data(32'h0),
      .i_mips_alu_result(alu), .i_mips_halt(1'b0), .o_step(step2),
      .o_mips_register_number(reg_num2), .o_mips_memory_address(mem_addr2),
      .o_instruction_write_enable(we2), .o_instruction_address(iaddr2),
      .o_instruction_data(idata2), .o_state_debug(state2));

   initial begin clk = 1'b0; forever #5 clk = ~clk; end

   // UART transmitter models: accept a byte, report done 3 cycles later.
   always @(negedge clk) begin
      tx_done = 1'b0;
      if (!rst_n) tcnt0 = 0;
      else if (tx_ready) begin txq.push_back(tx_data); tcnt0 = 3; end
      else if (tcnt0 != 0) begin tcnt0--; if (tcnt0 == 0) tx_done = 1'b1; end
      if (step) steps0++;
      if (we) begin waq.push_back(iaddr); wdq.push_back(idata); end
   end
   always @(negedge clk) begin
      tx2_done = 1'b0;
      if (!rst_n) tcnt2 = 0;
      else if (tx2_ready) begin txn2++; tcnt2 = 3; end
      else if (tcnt2 != 0) begin tcnt2--; if (tcnt2 == 0) tx2_done = 1'b1; end
      if (step2) steps2++;
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input int which, input logic [7:0] b);
      @(negedge clk);
      if (which == 0) begin rx_ready = 1'b1; rx_data = b; end
      else begin rx2_ready = 1'b1; rx2_data = b; end
      @(negedge clk);
      rx_ready = 1'b0; rx2_ready = 1'b0;
   endtask

   task automatic wait_idle(input int which);
      bit done = 0;
      for (int i = 0; i < 6000 && !done; i++) begin
         @(negedge clk);
         if (which == 0) done = (state == 4'd0 && tcnt0 == 0 && !tx_ready);
         else done = (state2 == 4'd0 && tcnt2 == 0 && !tx2_ready);
      end
      if (!done) chk("wait_idle_timeout", 64'd1, 64'd0);
   endtask

   function automatic logic [31:0] exp_word(input int w);
      if (w == 0) return pc;
      if (w <= 32) return reg_val(w - 1, zero_mode);
      if (w <= 48) return mem_val((w - 33) * 4, zero_mode);
      return alu;
   endfunction

   task automatic check_dump(input int base);
      logic [7:0] x = 8'h0;
      for (int w = 0; w < 50; w++) begin
         logic [31:0] got = {txq[base+4*w+3], txq[base+4*w+2], txq[base+4*w+1], txq[base+4*w]};
         chk($sformatf("dump_word%0d", w), got, exp_word(w));
         x = x ^ got[31:24] ^ got[23:16] ^ got[15:8] ^ got[7:0];
      end
`ifdef DEBUG_DUMP_CHECKSUM_EN
      chk("dump_checksum", txq[base+200], x);
`endif
   endtask

   typedef struct {
      string            name;
      logic [9:0][7:0]  b;      // b[9] is sent first
      int               nb, we, tx, steps;
      logic [7:0]       tx0;
      logic [1:0][31:0] wa, wd;
   } vec_t;
   vec_t vecs[5];

   initial begin
      int base, sbase, wbase, n;
      rst_n = 1'b0; rx_ready = 0; rx2_ready = 0; rx_data = 0; rx2_data = 0;
      pc = 32'h4; alu = 32'hDEADBEEF; halt = 0; zero_mode = 0;

      vecs[0] = '{"load2", {8'h4C,8'h02,8'h13,8'h00,8'h02,8'h20,8'h14,8'h00,8'h03,8'h20},
                  10, 2, 1, 0, 8'h06, {32'h4, 32'h0}, {32'h20030014, 32'h20020013}};
      vecs[1] = '{"load0", {8'h4C,8'h00,64'h0}, 2, 0, 1, 0, 8'h06, '0, '0};
      vecs[2] = '{"unknown", {8'h7A,72'h0}, 1, 0, 0, 0, 8'h00, '0, '0};
      vecs[3] = '{"step", {8'h53,72'h0}, 1, 0, DUMP_BYTES, 1, 8'h04, '0, '0};
      vecs[4] = '{"dump", {8'h44,72'h0}, 1, 0, DUMP_BYTES, 0, 8'h04, '0, '0};

      #1;
      chk("reset_outputs", |{tx_ready, tx_data, step, reg_num, mem_addr, we, iaddr, idata}, 0);
      chk("reset_state", state, 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;

      foreach (vecs[v]) begin
         base = txq.size(); sbase = steps0; wbase = waq.size();
         for (int i = 0; i < vecs[v].nb; i++) send_byte(0, vecs[v].b[9-i]);
         wait_idle(0);
         chk({vecs[v].name, "_tx_count"}, txq.size() - base, vecs[v].tx);
         chk({vecs[v].name, "_steps"}, steps0 - sbase, vecs[v].steps);
         chk({vecs[v].name, "_writes"}, waq.size() - wbase, vecs[v].we);
         chk({vecs[v].name, "_state"}, state, 0);
         if (txq.size() > base) chk({vecs[v].name, "_tx0"}, txq[base], vecs[v].tx0);
         for (int k = 0; k < vecs[v].we && wbase + k < waq.size(); k++) begin
            chk($sformatf("%s_waddr%0d", vecs[v].name, k), waq[wbase+k], vecs[v].wa[k]);
            chk($sformatf("%s_wdata%0d", vecs[v].name, k), wdq[wbase+k], vecs[v].wd[k]);
         end
         if (vecs[v].tx >= 200 && txq.size() - base >= DUMP_BYTES) check_dump(base);
      end

      // Continuous run, halt raised after 10 steps.
      base = txq.size(); sbase = steps0; n = 0;
      @(negedge clk); rx_ready = 1'b1; rx_data = 8'h43;
      for (int i = 0; i < 200 && n < 10; i++) begin
         @(negedge clk); rx_ready = 1'b0;
         if (step) n++;
         if (n == 10) halt = 1'b1;
      end
      chk("run_reached_10", n, 10);
      @(negedge clk);
      chk("run_stop_after_halt", step, 0);
      wait_idle(0); halt = 1'b0;
      chk("run_steps", steps0 - sbase, 10);
      chk("run_tx_count", txq.size() - base, DUMP_BYTES);

      // Halt already high on entry: exactly one step.
      halt = 1'b1; sbase = steps0; base = txq.size();
      send_byte(0, 8'h43); wait_idle(0); halt = 1'b0;
      chk("run_halt_entry_steps", steps0 - sbase, 1);
      chk("run_halt_entry_tx", txq.size() - base, DUMP_BYTES);

      // Watchdog on the small instance.
      send_byte(1, 8'h43); wait_idle(1);
      chk("watchdog_steps", steps2, 5);
      chk("watchdog_tx", txn2, DUMP2_BYTES);

      // Bytes arriving mid-dump are dropped.
      base = txq.size(); sbase = steps0; wbase = waq.size();
      send_byte(0, 8'h44); send_byte(0, 8'h4C); send_byte(0, 8'h02); send_byte(0, 8'h53);
      wait_idle(0);
      chk("busy_tx", txq.size() - base, DUMP_BYTES);
      chk("busy_steps", steps0 - sbase, 0);
      chk("busy_writes", waq.size() - wbase, 0);
      if (txq.size() - base >= DUMP_BYTES) check_dump(base);

      // Reset in the middle of a dump.
      base = txq.size();
      send_byte(0, 8'h44);
      for (int i = 0; i < 3000 && txq.size() - base < 20; i++) @(negedge clk);
      chk("middump_progress", txq.size() - base >= 20, 1);
      rst_n = 1'b0; #1;
      chk("middump_rst_outputs", |{tx_ready, tx_data, step, reg_num, mem_addr, we, iaddr, idata}, 0);
      chk("middump_rst_state", state, 0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      repeat (5) @(negedge clk);
      chk("after_rst_state", state, 0);

      // Checksum pattern: everything zero except PC.
      zero_mode = 1'b1; pc = 32'h01020304; alu = 32'h0; base = txq.size();
      send_byte(0, 8'h44); wait_idle(0);
      chk("zero_dump_tx", txq.size() - base, DUMP_BYTES);
      if (txq.size() - base >= DUMP_BYTES) begin
         check_dump(base);
`ifdef DEBUG_DUMP_CHECKSUM_EN
         chk("zero_dump_last", txq[base+200], 8'h04);
`endif
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/debug_bridge.md
Name: debug_bridge

Overview:
- Parametrised UART-side debug controller for the pipelined MIPS core; successor to the fixed 32-bit/8-bit debug unit.
- Sits between the UART receiver/transmitter byte handshakes and the PIPELINE debug ports.
- Decodes single-byte commands: program load, single step, continuous run and state dump.
- Serialises NB-bit words into DATA_BITS-wide bytes with a configurable register and memory dump depth.

Parameters:
- NB, 32, datapath word width; must be a multiple of DATA_BITS.
- DATA_BITS, 8, UART byte width.
- NUM_REGS, 32, registers dumped, indices 0..NUM_REGS-1.
- MEM_DUMP_DEPTH, 16, data-memory words dumped, word addresses 0..MEM_DUMP_DEPTH-1.
- IMEM_DEPTH, 256, instruction memory depth in words; a power of two.
- MAX_RUN_CYCLES, 65535, continuous-run watchdog limit.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_uart_rx_ready  in  1  one-cycle pulse: byte valid on i_uart_rx_data.
- i_uart_rx_data  in  DATA_BITS  received byte.
- i_uart_tx_done  in  1  one-cycle pulse: previous byte fully transmitted.
- o_uart_tx_ready  out  1  one-cycle start pulse to the transmitter.
- o_uart_tx_data  out  DATA_BITS  byte to send; held stable until i_uart_tx_done.
- i_mips_pc  in  NB  current PC.
- i_mips_register  in  NB  register-file read data for o_mips_register_number.
- i_mips_mem_data  in  NB  data-memory read data for o_mips_memory_address.
- i_mips_alu_result  in  NB  latest ALU result.
- i_mips_halt  in  1  core has executed a halt instruction.
- o_step  out  1  pipeline clock enable.
- o_mips_register_number  out  NB  register index; upper bits zero.
- o_mips_memory_address  out  NB  byte address, equal to word index times NB/8.
- o_instruction_write_enable  out  1  one-cycle instruction-memory write strobe.
- o_instruction_address  out  NB  byte address of the write.
- o_instruction_data  out  NB  instruction word to write.
- o_state_debug  out  4  current FSM state code, for LEDs.

Behaviour:
- Reset (asynchronous, active-low):
  - All outputs go to 0 and the FSM enters IDLE immediately, including mid-load, mid-run or mid-dump.
  - Any partial word and all counters are discarded.
- Command bytes, accepted only in IDLE:
  - 0x4C 'L': load.
  - 0x53 'S': step.
  - 0x43 'C': continuous run.
  - 0x44 'D': dump.
  - Any other byte is ignored; the FSM stays in IDLE.
- Bytes received in any state other than IDLE, LOAD_CNT or LOAD_DATA are dropped.
- States and codes: IDLE=0, LOAD_CNT=1, LOAD_DATA=2, LOAD_ACK=3, STEP=4, RUN=5, DUMP_FETCH=6, DUMP_SEND=7, DUMP_WAIT=8, CHK_SEND=9.
- Load:
  - LOAD_CNT takes the next byte as word count N. N=0 goes directly to LOAD_ACK.
  - LOAD_DATA assembles NB/DATA_BITS bytes per word, least-significant byte first.
  - On the final byte of each word, pulse o_instruction_write_enable for 1 cycle. Address = (word index mod IMEM_DEPTH) times NB/8; the index wraps.
  - After N words, LOAD_ACK sends byte 0x06, then returns to IDLE.
- Step:
  - STEP drives o_step=1 for exactly one cycle, then enters the dump sequence.
- Continuous run:
  - RUN holds o_step=1 until i_mips_halt=1 or MAX_RUN_CYCLES steps have elapsed, whichever comes first, then enters the dump sequence.
  - o_step deasserts in the cycle after i_mips_halt is sampled high.
  - If i_mips_halt is already high on entry, exactly one step is issued.
- Dump sequence, word order:
  - PC.
  - Registers 0..NUM_REGS-1.
  - Memory words 0..MEM_DUMP_DEPTH-1.
  - ALU result.
- DUMP_FETCH:
  - Drives the register or memory address, waits 1 cycle for read latency, then latches the word.
  - PC and ALU result are latched directly.
- Word transmission:
  - DUMP_SEND pulses o_uart_tx_ready with the least-significant byte first.
  - DUMP_WAIT waits for i_uart_tx_done.
  - Total bytes per dump = (NUM_REGS + MEM_DUMP_DEPTH + 2) times NB/DATA_BITS.
  - Returns to IDLE after the last i_uart_tx_done.
- o_step is 0 in every state except STEP and RUN.

Optional Feature:
- Macro: DEBUG_DUMP_CHECKSUM_EN.
- Defined:
  - A running XOR of all dump bytes is kept, cleared at the start of each dump.
  - After the last dump byte, CHK_SEND transmits the checksum byte, then returns to IDLE.
  - Load ACK is unaffected.
- Undefined: state 9 is unreachable, no checksum logic is synthesised, and the dump ends after the ALU-result word.

Test Plan:
- Load: send 0x4C, 0x02, then bytes 13 00 02 20 and 14 00 03 20.
  - Two write strobes: addr 0x0 data 0x20020013, and addr 0x4 data 0x20030014.
  - TX byte 0x06.
- Load with N=0: send 0x4C, 0x00 -> no write strobe, TX 0x06, FSM back in IDLE.
- Step with defaults: send 0x53 -> o_step high for exactly 1 cycle.
  - Exactly 200 TX bytes follow (50 words × 4).
  - The first 4 bytes equal the PC LSB-first, e.g. PC 0x00000004 -> 04 00 00 00.
- Continuous run: send 0x43, raise i_mips_halt after 10 steps -> o_step low the next cycle, then a full dump.
  - With MAX_RUN_CYCLES=5 and no halt, exactly 5 o_step cycles.
- Robustness:
  - Unknown byte 0x7A in IDLE -> no TX, no step.
  - Bytes received during a dump -> ignored.
  - Reset asserted (low) mid-dump -> all outputs 0 and o_state_debug=0 immediately.
- Checksum (DEBUG_DUMP_CHECKSUM_EN defined): dump with all inputs 0 except PC 0x01020304 -> 201 bytes, the last equal to 0x04.
